// File: rtl/adder2_nor_mux_unit_if.sv
// Operand/result bundle for adder2_nor_mux_unit.
// The mismatch signal exists only when ADDER2_XCHK_EN is defined.
interface adder2_nor_mux_unit_if;
    logic in_valid;
    logic a1, a0;
    logic b1, b0;
    logic c0;
    logic out_valid;
    logic c1, s1, s0;
`ifdef ADDER2_XCHK_EN
    logic mismatch;
`endif

`ifdef ADDER2_XCHK_EN
    modport master (
        output in_valid, a1, a0, b1, b0, c0,
        input  out_valid, c1, s1, s0, mismatch
    );
    modport slave (
        input  in_valid, a1, a0, b1, b0, c0,
        output out_valid, c1, s1, s0, mismatch
    );
`else
    modport master (
        output in_valid, a1, a0, b1, b0, c0,
        input  out_valid, c1, s1, s0
    );
    modport slave (
        input  in_valid, a1, a0, b1, b0, c0,
        output out_valid, c1, s1, s0
    );
`endif
endinterface

// File: rtl/adder2_nor_mux_unit.sv
// Registered 2-bit full adder built from a NOR-only gate network.
// Define ADDER2_XCHK_EN to add a mux-based redundant path and a registered mismatch flag.
module adder2_nor_mux_unit (
    input logic                  clk,
    input logic                  rst,
    adder2_nor_mux_unit_if.slave bus
);

    function automatic logic nor2(input logic x, input logic y);
        return ~(x | y);
    endfunction

    // Returns {carry, sum}; every gate is a 2-input NOR.
    function automatic logic [1:0] nor_slice(input logic a, input logic b, input logic c);
        logic n_ab, p_ab, q_ab, xn_ab, x_ab;
        logic n_xc, p_xc, q_xc, xn_xc, sum;
        logic n_bc, n_ac, t, carry;
        n_ab  = nor2(a, b);
        p_ab  = nor2(a, n_ab);
        q_ab  = nor2(b, n_ab);
        xn_ab = nor2(p_ab, q_ab);
        x_ab  = nor2(xn_ab, xn_ab);
        n_xc  = nor2(x_ab, c);
        p_xc  = nor2(x_ab, n_xc);
        q_xc  = nor2(c, n_xc);
        xn_xc = nor2(p_xc, q_xc);
        sum   = nor2(xn_xc, xn_xc);
        // maj = (a|b)&(b|c)&(a|c) expressed as NORs of the pairwise NORs
        n_bc  = nor2(b, c);
        n_ac  = nor2(a, c);
        t     = nor2(n_ab, n_bc);
        carry = nor2(nor2(t, t), n_ac);
        return {carry, sum};
    endfunction

    logic [1:0] nor_lo, nor_hi;
    logic [2:0] nor_sum;

    always_comb begin
        nor_lo  = nor_slice(bus.a0, bus.b0, bus.c0);
        nor_hi  = nor_slice(bus.a1, bus.b1, nor_lo[1]);
        nor_sum = {nor_hi, nor_lo[0]};
    end

`ifdef ADDER2_XCHK_EN
    function automatic logic [1:0] mux_slice(input logic a, input logic b, input logic c);
        logic x;
        x = a ^ b;
        return {(x ? c : a), (c ? ~x : x)};
    endfunction

    logic [1:0] mux_lo, mux_hi;
    logic [2:0] mux_sum;

    always_comb begin
        mux_lo  = mux_slice(bus.a0, bus.b0, bus.c0);
        mux_hi  = mux_slice(bus.a1, bus.b1, mux_lo[1]);
        mux_sum = {mux_hi, mux_lo[0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mismatch <= 1'b0;
        end else begin
            bus.mismatch <= bus.in_valid && (nor_sum != mux_sum);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.c1        <= 1'b0;
            bus.s1        <= 1'b0;
            bus.s0        <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                {bus.c1, bus.s1, bus.s0} <= nor_sum;
            end
        end
    end

endmodule

// File: tb/tb_adder2_nor_mux_unit.sv
// Directed self-checking bench for adder2_nor_mux_unit.
module tb_adder2_nor_mux_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    adder2_nor_mux_unit_if bus ();

    adder2_nor_mux_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [1:0] a, input logic [1:0] b,
                         input logic c);
        bus.in_valid = iv;
        {bus.a1, bus.a0} = a;
        {bus.b1, bus.b0} = b;
        bus.c0 = c;
    endtask

    // Drive, take one rising edge, then sample 1 time unit later.
    task automatic step(input logic iv, input logic [1:0] a, input logic [1:0] b,
                        input logic c);
        drive(iv, a, b, c);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] res();
        return {5'd0, bus.c1, bus.s1, bus.s0};
    endfunction

    task automatic check_mm(input string tag);
`ifdef ADDER2_XCHK_EN
        check(tag, {7'd0, bus.mismatch}, 8'd0);
`endif
    endtask

    initial begin
        logic [1:0] av, bv;
        logic       cv;
        logic [2:0] expv;
        checks = 0;
        errors = 0;

        // Reset held with random inputs
        rst = 1'b1;
        drive(1'b0, 2'b00, 2'b00, 1'b0);
        #1;
        for (int i = 0; i < 4; i++) begin
            step(1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom));
            check("rst_data", res(), 8'd0);
            check("rst_valid", {7'd0, bus.out_valid}, 8'd0);
            check_mm("rst_mm");
        end
        drive(1'b0, 2'b00, 2'b00, 1'b0);
        #2;
        rst = 1'b0;

        // Directed vectors
        step(1'b1, 2'b11, 2'b10, 1'b1);
        check("v_11_10_1", res(), 8'b110);
        check("v_11_10_1_valid", {7'd0, bus.out_valid}, 8'd1);
        step(1'b1, 2'b10, 2'b00, 1'b0);
        check("v_10_00_0", res(), 8'b010);
        step(1'b1, 2'b10, 2'b10, 1'b1);
        check("v_10_10_1", res(), 8'b101);
        step(1'b1, 2'b00, 2'b01, 1'b0);
        check("v_00_01_0", res(), 8'b001);
        step(1'b1, 2'b10, 2'b00, 1'b1);
        check("v_10_00_1", res(), 8'b011);
        step(1'b1, 2'b10, 2'b11, 1'b1);
        check("v_10_11_1", res(), 8'b110);
        step(1'b1, 2'b11, 2'b11, 1'b1);
        check("b_max", res(), 8'b111);
        step(1'b1, 2'b00, 2'b00, 1'b0);
        check("b_zero", res(), 8'b000);
        check("b_zero_valid", {7'd0, bus.out_valid}, 8'd1);

        // Exhaustive sweep of all 32 operand combinations
        for (int i = 0; i < 32; i++) begin
            av = 2'(i >> 3);
            bv = 2'(i >> 1);
            cv = 1'(i);
            expv = 3'(av) + 3'(bv) + 3'(cv);
            step(1'b1, av, bv, cv);
            check($sformatf("ex_%0d", i), res(), {5'd0, expv});
            check($sformatf("ex_valid_%0d", i), {7'd0, bus.out_valid}, 8'd1);
            check_mm($sformatf("ex_mm_%0d", i));
        end

        // Hold: in_valid low keeps the last result
        step(1'b1, 2'b10, 2'b10, 1'b1);
        check("hold_load", res(), 8'b101);
        step(1'b0, 2'b11, 2'b11, 1'b1);
        check("hold_data", res(), 8'b101);
        check("hold_valid", {7'd0, bus.out_valid}, 8'd0);
        check_mm("hold_mm");
        step(1'b0, 2'b01, 2'b00, 1'b0);
        check("hold_data2", res(), 8'b101);

        // Mid-stream asynchronous reset clears without a clock edge
        step(1'b1, 2'b11, 2'b11, 1'b1);
        check("pre_rst", res(), 8'b111);
        rst = 1'b1;
        #1;
        check("async_rst_data", res(), 8'd0);
        check("async_rst_valid", {7'd0, bus.out_valid}, 8'd0);
        #1;
        rst = 1'b0;
        step(1'b1, 2'b01, 2'b01, 1'b1);
        check("post_rst", res(), 8'b011);
        check("post_rst_valid", {7'd0, bus.out_valid}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
